// File: rtl/ahb_bm_input_stage.sv
// AHB bus matrix master-side input stage.
// Holds an ungranted address phase and relays the slave data phase.
module ahb_bm_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  req_port,
  input  logic                  grant_port,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM,
  input  logic                  HREADYM,
  input  logic                  HRESPM
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } ap_t;

  ap_t  live;
  ap_t  hold_q;
  ap_t  mux;
  logic held;
  logic dphase;
  logic held_d;
  logic dphase_d;
  logic live_valid;
  logic accept;
  logic capture;

  assign live = '{
    addr:  HADDRS,
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  assign live_valid = HSELS & HREADYS & HTRANSS[1];

  always_comb begin
    mux = live;
    if (held) begin
      mux = hold_q;
    end else if (!live_valid) begin
      mux.trans = 2'b00;
    end
  end

  assign accept  = grant_port & HREADYM & mux.trans[1];
  assign capture = live_valid & ~accept;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      held   <= 1'b0;
      dphase <= 1'b0;
      hold_q <= '0;
    end else begin
      held   <= held_d;
      dphase <= dphase_d;
      if (capture) begin
        hold_q <= live;
      end
    end
  end

  always_comb begin
    held_d   = held;
    dphase_d = dphase;
    if (capture) begin
      held_d = 1'b1;
    end else if (held && accept) begin
      held_d = 1'b0;
    end
    if (accept) begin
      dphase_d = 1'b1;
    end else if (HREADYM) begin
      dphase_d = 1'b0;
    end
  end

  always_comb begin
    HREADYOUTS = dphase ? HREADYM : ~held;
    HRESPS     = dphase & HRESPM;
    req_port   = held | live_valid;
    HADDRM     = mux.addr;
    HTRANSM    = mux.trans;
    HWRITEM    = mux.write;
    HSIZEM     = mux.size;
    HBURSTM    = mux.burst;
    HPROTM     = mux.prot;
    HMASTLOCKM = mux.lock;
  end

  // a beat is either waiting for its grant or in its data phase, never both
  illegal_state: assert property (
    @(posedge HCLK) disable iff (HRESET) !(held && dphase)
  );

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Scoreboard bench for ahb_bm_input_stage.
// Directed cycles push expected port values; a monitor checks them.
module tb_ahb_bm_input_stage;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req_port;
  logic        grant_port;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM;
  logic [2:0]  HBURSTM;
  logic [3:0]  HPROTM;
  logic        HMASTLOCKM;
  logic        HREADYM;
  logic        HRESPM;

  ahb_bm_input_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HWRITES    (HWRITES),
    .HSIZES     (HSIZES),
    .HBURSTS    (HBURSTS),
    .HPROTS     (HPROTS),
    .HMASTLOCKS (HMASTLOCKS),
    .HREADYS    (HREADYS),
    .HREADYOUTS (HREADYOUTS),
    .HRESPS     (HRESPS),
    .req_port   (req_port),
    .grant_port (grant_port),
    .HADDRM     (HADDRM),
    .HTRANSM    (HTRANSM),
    .HWRITEM    (HWRITEM),
    .HSIZEM     (HSIZEM),
    .HBURSTM    (HBURSTM),
    .HPROTM     (HPROTM),
    .HMASTLOCKM (HMASTLOCKM),
    .HREADYM    (HREADYM),
    .HRESPM     (HRESPM)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          id;
    logic        rdy;
    logic        resp;
    logic        req;
    logic [1:0]  trans;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  always @(negedge HCLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (HREADYOUTS !== e.rdy || HRESPS !== e.resp ||
          req_port !== e.req || HTRANSM !== e.trans ||
          HADDRM !== e.addr) begin
        errors++;
        $display("FAIL step%0d got rdy=%b resp=%b req=%b tr=%b a=%h want rdy=%b resp=%b req=%b tr=%b a=%h",
                 e.id, HREADYOUTS, HRESPS, req_port, HTRANSM, HADDRM,
                 e.rdy, e.resp, e.req, e.trans, e.addr);
      end
    end
  end

  task automatic cyc(
    input logic        rst,
    input logic        sel,
    input logic [1:0]  tr,
    input logic [31:0] a,
    input logic        rdys,
    input logic        gnt,
    input logic        rdym,
    input logic        rspm,
    input logic        x_rdy,
    input logic        x_resp,
    input logic        x_req,
    input logic [1:0]  x_tr,
    input logic [31:0] x_a
  );
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET     = rst;
    HSELS      = sel;
    HTRANSS    = tr;
    HADDRS     = a;
    HREADYS    = rdys;
    grant_port = gnt;
    HREADYM    = rdym;
    HRESPM     = rspm;
    step_id++;
    e.id    = step_id;
    e.rdy   = x_rdy;
    e.resp  = x_resp;
    e.req   = x_req;
    e.trans = x_tr;
    e.addr  = x_a;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    HRESET     = 1'b1;
    HSELS      = 1'b0;
    HADDRS     = '0;
    HTRANSS    = 2'b00;
    HWRITES    = 1'b1;
    HSIZES     = 3'd2;
    HBURSTS    = 3'd0;
    HPROTS     = 4'h3;
    HMASTLOCKS = 1'b0;
    HREADYS    = 1'b1;
    grant_port = 1'b0;
    HREADYM    = 1'b1;
    HRESPM     = 1'b0;
    @(posedge HCLK);
    //  rst sel tr     addr          rdys gnt rdm rsp | rdy rsp req tr    addr
    cyc(1, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // granted single write
    cyc(0, 1, 2'b10, 32'h2000_0010,  1, 1, 1, 0,  1, 0, 1, 2'b10, 32'h2000_0010);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // denied three cycles, then granted
    cyc(0, 1, 2'b10, 32'h4000_0004,  1, 0, 1, 0,  1, 0, 1, 2'b10, 32'h4000_0004);
    cyc(0, 1, 2'b10, 32'hDEAD_BEEF,  0, 0, 1, 0,  0, 0, 1, 2'b10, 32'h4000_0004);
    cyc(0, 1, 2'b10, 32'hDEAD_BEEF,  0, 0, 1, 0,  0, 0, 1, 2'b10, 32'h4000_0004);
    cyc(0, 1, 2'b10, 32'hDEAD_BEEF,  0, 0, 1, 0,  0, 0, 1, 2'b10, 32'h4000_0004);
    cyc(0, 1, 2'b10, 32'hDEAD_BEEF,  0, 1, 1, 0,  0, 0, 1, 2'b10, 32'h4000_0004);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // back-to-back: A granted, B arrives ungranted during A data phase
    cyc(0, 1, 2'b10, 32'h0000_0080,  1, 1, 1, 0,  1, 0, 1, 2'b10, 32'h0000_0080);
    cyc(0, 1, 2'b10, 32'h0000_0100,  1, 0, 1, 0,  1, 0, 1, 2'b10, 32'h0000_0100);
    cyc(0, 1, 2'b10, 32'h0000_0104,  0, 0, 1, 0,  0, 0, 1, 2'b10, 32'h0000_0100);
    cyc(0, 1, 2'b10, 32'h0000_0104,  0, 1, 1, 0,  0, 0, 1, 2'b10, 32'h0000_0100);
    // B data phase with two slave wait states
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 0, 0,  0, 0, 0, 2'b00, 32'h0);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 0, 0,  0, 0, 0, 2'b00, 32'h0);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // two-cycle ERROR response
    cyc(0, 1, 2'b10, 32'h0000_0300,  1, 1, 1, 0,  1, 0, 1, 2'b10, 32'h0000_0300);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 0, 1,  0, 1, 0, 2'b00, 32'h0);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 1,  1, 1, 0, 2'b00, 32'h0);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 1,  1, 0, 0, 2'b00, 32'h0);
    // reset while holding
    cyc(0, 1, 2'b10, 32'h0000_0500,  1, 0, 1, 0,  1, 0, 1, 2'b10, 32'h0000_0500);
    cyc(1, 0, 2'b00, 32'h0,          0, 0, 1, 0,  0, 0, 1, 2'b10, 32'h0000_0500);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // BUSY is neither requested nor captured
    cyc(0, 1, 2'b01, 32'h0000_0600,  1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0000_0600);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 1, 0,  1, 0, 0, 2'b00, 32'h0);
    // reset during a stalled data phase
    cyc(0, 1, 2'b10, 32'h0000_0700,  1, 1, 1, 0,  1, 0, 1, 2'b10, 32'h0000_0700);
    cyc(1, 0, 2'b00, 32'h0,          1, 0, 0, 1,  0, 1, 0, 2'b00, 32'h0);
    cyc(0, 0, 2'b00, 32'h0,          1, 0, 0, 1,  1, 0, 0, 2'b00, 32'h0);
    repeat (2) @(negedge HCLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
